// File: rtl/round_robin_arbiter_pkg.sv
// Shared constants and helpers for the packet-level round-robin arbiter.
// Index width is sized for the largest legal requester count.
package round_robin_arbiter_pkg;

    localparam int MAX_REQUEST = 32;
    localparam int IDX_W       = $clog2(MAX_REQUEST);

    // Input must be one-hot or zero; zero maps to index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQUEST-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQUEST; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_rr_priority_pick.sv
// Combinational rotating-priority pick: first set request at or after start_i,
// wrapping to 0, found with a double-width masked priority encoder.
import round_robin_arbiter_pkg::*;

module rr_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     pick_o,
    output logic             valid_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] pick_dbl;
    logic           found;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        dbl      = {req_i, req_i};
        masked   = '0;
        pick_dbl = '0;
        found    = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            masked[i] = dbl[i] && (i >= int'(start_i));
        end
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && masked[i]) begin
                found       = 1'b1;
                pick_dbl[i] = 1'b1;
            end
        end
        // Upper copy covers the wrapped part of the search; fold it back.
        pick_o  = pick_dbl[N-1:0] | pick_dbl[2*N-1:N];
        valid_o = |req_i;
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Packet-level round-robin arbiter: holds a one-hot grant for a whole packet,
// re-arbitrates at the last beat, and caps sole-requester back-to-back packets.
import round_robin_arbiter_pkg::*;

module round_robin_arbiter #(
    parameter int NUM_REQUEST = 4,
    parameter int MAX_PACKETS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQUEST-1:0] request_i,
    input  logic [NUM_REQUEST-1:0] s_last_i,
    output logic [NUM_REQUEST-1:0] grant_o
);

    localparam int CNT_W = $clog2(MAX_PACKETS + 1);

    logic [NUM_REQUEST-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [MAX_REQUEST-1:0] grant_ext;
    logic [IDX_W-1:0]       holder_idx;
    logic [IDX_W-1:0]       after_holder;
    logic [IDX_W-1:0]       search_start;
    logic [NUM_REQUEST-1:0] pick;
    logic                   pick_valid;
    logic                   busy;
    logic                   release_now;
    logic                   sole_requester;

    assign grant_ext    = MAX_REQUEST'(grant_q);
    assign holder_idx   = onehot_to_idx(grant_ext);
    assign after_holder = (holder_idx == IDX_W'(NUM_REQUEST - 1)) ? '0 : holder_idx + 1'b1;
    assign busy         = |grant_q;
    assign release_now  = busy && ((|(s_last_i & grant_q)) || !(|(request_i & grant_q)));
    // Holder still requesting and nobody else is: the only case where it keeps the port.
    assign sole_requester = (request_i == grant_q);
    assign search_start   = busy ? after_holder : ptr_q;

    rr_priority_pick #(
        .N (NUM_REQUEST)
    ) u_pick (
        .req_i   (request_i),
        .start_i (search_start),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!busy) begin
            if (pick_valid) begin
                grant_d = pick;
            end
        end else if (release_now) begin
            ptr_d = after_holder;
            if (sole_requester) begin
                // Cap reached: one idle cycle lets the pointer move past the hog.
                if (cnt_q == CNT_W'(MAX_PACKETS)) begin
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                grant_d = pick;
                cnt_d   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed table-driven bench for round_robin_arbiter (4 inputs, 2-packet cap),
// plus hand sequences for reset and asynchronous mid-packet reset.
module tb_round_robin_arbiter;

    localparam int NR    = 4;
    localparam int NVEC  = 25;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] last;
        logic [NR-1:0] exp_grant;
        string         name;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [NR-1:0] request_i;
    logic [NR-1:0] s_last_i;
    logic [NR-1:0] grant_o;

    int n_total;
    int n_pass;

    vec_t vecs [NVEC];

    round_robin_arbiter #(
        .NUM_REQUEST (NR),
        .MAX_PACKETS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .request_i (request_i),
        .s_last_i  (s_last_i),
        .grant_o   (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [NR-1:0] actual, input logic [NR-1:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: grant_o=%b expected %b", name, actual, expected);
        end
    endtask

    task automatic check_onehot(input string name);
        n_total++;
        if ($countones(grant_o) <= 1 && !$isunknown(grant_o)) begin
            n_pass++;
        end else begin
            $display("FAIL %s onehot: grant_o=%b expected at most one bit", name, grant_o);
        end
    endtask

    // Drive inputs, let one rising edge sample them, then look at the result.
    task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] last);
        request_i = req;
        s_last_i  = last;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        request_i = 4'b1111;
        s_last_i  = 4'b0000;

        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, "idle_no_req_a"};
        vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, "idle_no_req_b"};
        vecs[2]  = '{4'b0101, 4'b0000, 4'b0001, "idle_pick_from_0"};
        vecs[3]  = '{4'b0101, 4'b0000, 4'b0001, "hold_mid_packet"};
        vecs[4]  = '{4'b0110, 4'b0001, 4'b0010, "rot_0_to_1"};
        vecs[5]  = '{4'b1101, 4'b0010, 4'b0100, "rot_1_to_2"};
        vecs[6]  = '{4'b1011, 4'b0100, 4'b1000, "rot_2_to_3"};
        vecs[7]  = '{4'b0011, 4'b1000, 4'b0001, "rot_wrap_3_to_0"};
        vecs[8]  = '{4'b0010, 4'b0001, 4'b0010, "rot_0_to_1_again"};
        vecs[9]  = '{4'b0011, 4'b0001, 4'b0010, "stale_last_1"};
        vecs[10] = '{4'b0011, 4'b0001, 4'b0010, "stale_last_2"};
        vecs[11] = '{4'b0011, 4'b0001, 4'b0010, "stale_last_3"};
        vecs[12] = '{4'b1001, 4'b0000, 4'b1000, "req_drop_moves"};
        vecs[13] = '{4'b0000, 4'b1000, 4'b0000, "release_no_req"};
        vecs[14] = '{4'b0100, 4'b0000, 4'b0100, "sole_idle_grant"};
        vecs[15] = '{4'b0100, 4'b0100, 4'b0100, "sole_regrant_1"};
        vecs[16] = '{4'b0100, 4'b0000, 4'b0100, "sole_mid_packet"};
        vecs[17] = '{4'b0100, 4'b0100, 4'b0100, "sole_regrant_2"};
        vecs[18] = '{4'b0100, 4'b0100, 4'b0000, "sole_cap_bubble"};
        vecs[19] = '{4'b0100, 4'b0000, 4'b0100, "sole_after_bubble"};
        vecs[20] = '{4'b0100, 4'b0100, 4'b0100, "sole_count_restart"};
        vecs[21] = '{4'b1111, 4'b0100, 4'b1000, "all_req_after_2"};
        vecs[22] = '{4'b0111, 4'b1000, 4'b0001, "wrap_search_from_0"};
        vecs[23] = '{4'b0110, 4'b0001, 4'b0010, "ptr_to_1"};
        vecs[24] = '{4'b0110, 4'b0000, 4'b0010, "hold_before_reset"};

        // Reset held with everyone requesting: no grant may appear.
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", grant_o, 4'b0000);
        rst       = 1'b0;
        request_i = 4'b0000;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].req, vecs[i].last);
            check(vecs[i].name, grant_o, vecs[i].exp_grant);
            check_onehot(vecs[i].name);
        end

        // Mid-packet asynchronous reset: grant must clear before any clock edge.
        rst = 1'b1;
        #1;
        check("async_reset_no_edge", grant_o, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Pointer was 1 before reset; after reset the search restarts at 0.
        step(4'b1001, 4'b0000);
        check("post_reset_ptr_0", grant_o, 4'b0001);
        step(4'b1001, 4'b0001);
        check("post_reset_rotate", grant_o, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
